// File: rtl/boss_health_fsm_pkg.sv
// Shared types and defaults for the boss health state machine and its timers.
package boss_pkg;

  localparam int HIT_W = 4;

  localparam int DEF_MAX_HITS     = 10;
  localparam int DEF_ENRAGE_HITS  = 5;
  localparam int DEF_FLASH_FRAMES = 8;
  localparam int DEF_DEATH_FRAMES = 60;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ALIVE    = 3'd1,
    ENRAGED  = 3'd2,
    DYING    = 3'd3,
    DEFEATED = 3'd4
  } boss_state_t;

  // Remaining health: max_hits - hits, floored at zero, done one bit wider
  // than the hit count so the subtraction can never wrap.
  function automatic logic [HIT_W-1:0] calc_health(
    input logic [HIT_W:0] max_hits,
    input logic [HIT_W:0] hits
  );
    logic [HIT_W:0] diff;
    if (hits >= max_hits) begin
      diff = '0;
    end else begin
      diff = max_hits - hits;
    end
    return diff[HIT_W-1:0];
  endfunction

endpackage

// File: rtl/boss_frame_timer.sv
// Frame-rate down-counter: clear beats load, load beats a frame_tick decrement.
// done_o flags that the current tick takes the counter from 1 to 0.
module boss_frame_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         clear_i,
  input  logic         tick_i,
  output logic         zero_o,
  output logic         done_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear, reload, or decrement on a frame tick while nonzero.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (tick_i && (count_q != '0)) begin
      count_d = count_q - W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);
  assign done_o = tick_i && (count_q == W'(1));

endmodule

// File: rtl/boss_health_fsm.sv
// Boss health / enrage / hit-flash / death-sequence controller driven by the
// cumulative hit counter. All outputs come straight from flops.
module boss_health_fsm
  import boss_pkg::*;
#(
  parameter int MAX_HITS     = DEF_MAX_HITS,
  parameter int ENRAGE_HITS  = DEF_ENRAGE_HITS,
  parameter int FLASH_FRAMES = DEF_FLASH_FRAMES,
  parameter int DEATH_FRAMES = DEF_DEATH_FRAMES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             frame_tick,
  input  logic [HIT_W-1:0] hit_count,
  output logic [HIT_W-1:0] health,
  output logic             boss_active,
  output logic             boss_enraged,
  output logic             boss_flash,
  output logic             boss_exploding,
  output logic             boss_defeated,
  output logic             defeat_pulse
);

  localparam int H5 = HIT_W + 1;
  localparam int FW = $clog2(FLASH_FRAMES + 1);
  localparam int DW = $clog2(DEATH_FRAMES + 1);

  localparam logic [H5-1:0] MAX5       = H5'(MAX_HITS);
  localparam logic [H5-1:0] ENR5       = H5'(ENRAGE_HITS);
  localparam logic [FW-1:0] FLASH_LOAD = FW'(FLASH_FRAMES);
  localparam logic [DW-1:0] DEATH_LOAD = DW'(DEATH_FRAMES);

  boss_state_t      state_q, state_d;
  logic [HIT_W-1:0] hits_q, hits_d;
  logic [HIT_W-1:0] prev_q;
  logic [HIT_W-1:0] delta_s;
  logic [H5-1:0]    sum_s;
  logic [H5-1:0]    sat_s;

  logic flash_load_s, flash_clr_s, flash_zero_s, flash_done_s;
  logic death_load_s, death_clr_s, death_zero_s, death_done_s;
  logic death_expire_s;
  logic active_d_s, flash_next_on_s;

  logic [HIT_W-1:0] health_q;
  logic active_q, enraged_q, flash_q, exploding_q, defeated_q, pulse_q;

  boss_frame_timer #(.W(FW)) u_flash_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (flash_load_s),
    .load_val_i (FLASH_LOAD),
    .clear_i    (flash_clr_s),
    .tick_i     (frame_tick),
    .zero_o     (flash_zero_s),
    .done_o     (flash_done_s)
  );

  boss_frame_timer #(.W(DW)) u_death_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (death_load_s),
    .load_val_i (DEATH_LOAD),
    .clear_i    (death_clr_s),
    .tick_i     (frame_tick),
    .zero_o     (death_zero_s),
    .done_o     (death_done_s)
  );

  // The explosion ends on the tick that takes the death timer from 1 to 0.
  assign death_expire_s = death_done_s && !death_zero_s;

  // Next state, hit accumulation and timer controls; start overrides any hit.
  always_comb begin
    delta_s      = hit_count - prev_q;
    sum_s        = {1'b0, hits_q} + {1'b0, delta_s};
    sat_s        = (sum_s >= MAX5) ? MAX5 : sum_s;
    state_d      = state_q;
    hits_d       = hits_q;
    flash_load_s = 1'b0;
    flash_clr_s  = 1'b0;
    death_load_s = 1'b0;
    death_clr_s  = 1'b0;
    if (start) begin
      state_d     = ALIVE;
      hits_d      = '0;
      flash_clr_s = 1'b1;
      death_clr_s = 1'b1;
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        ALIVE, ENRAGED: begin
          if (delta_s != '0) begin
            hits_d       = sat_s[HIT_W-1:0];
            flash_load_s = 1'b1;
            if (sat_s >= MAX5) begin
              // Straight to the explosion; the flash is killed on entry.
              state_d      = DYING;
              death_load_s = 1'b1;
              flash_clr_s  = 1'b1;
            end else if ((state_q == ALIVE) && (sat_s >= ENR5)) begin
              state_d = ENRAGED;
            end else begin
              state_d = state_q;
            end
          end else begin
            state_d = state_q;
          end
        end
        DYING: begin
          if (death_expire_s) begin
            state_d = DEFEATED;
          end else begin
            state_d = DYING;
          end
        end
        DEFEATED: state_d = DEFEATED;
        default: begin
          state_d = IDLE;
          hits_d  = '0;
        end
      endcase
    end
  end

  // Predict the flash timer's next nonzero-ness so boss_flash can be a flop.
  always_comb begin
    active_d_s = (state_d == ALIVE) || (state_d == ENRAGED);
    if (flash_clr_s) begin
      flash_next_on_s = 1'b0;
    end else if (flash_load_s) begin
      flash_next_on_s = (FLASH_LOAD != '0);
    end else if (flash_zero_s || flash_done_s) begin
      flash_next_on_s = 1'b0;
    end else begin
      flash_next_on_s = 1'b1;
    end
  end

  // State, accumulator, hit-count tracker and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      hits_q      <= '0;
      prev_q      <= '0;
      health_q    <= MAX5[HIT_W-1:0];
      active_q    <= 1'b0;
      enraged_q   <= 1'b0;
      flash_q     <= 1'b0;
      exploding_q <= 1'b0;
      defeated_q  <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      hits_q      <= hits_d;
      prev_q      <= hit_count;
      health_q    <= calc_health(MAX5, {1'b0, hits_d});
      active_q    <= active_d_s;
      enraged_q   <= (state_d == ENRAGED);
      flash_q     <= active_d_s && flash_next_on_s;
      exploding_q <= (state_d == DYING);
      defeated_q  <= (state_d == DEFEATED);
      pulse_q     <= (state_d == DEFEATED) && (state_q != DEFEATED);
    end
  end

  assign health         = health_q;
  assign boss_active    = active_q;
  assign boss_enraged   = enraged_q;
  assign boss_flash     = flash_q;
  assign boss_exploding = exploding_q;
  assign boss_defeated  = defeated_q;
  assign defeat_pulse   = pulse_q;

endmodule

// File: tb/tb_boss_health_fsm.sv
// Self-checking bench: directed scenarios followed by random play, every cycle
// compared against a behavioural model of the boss.
module tb_boss_health_fsm;

  localparam int MAXH = 10;
  localparam int ENR  = 5;
  localparam int FLF  = 8;
  localparam int DTH  = 60;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       frame_tick;
  logic [3:0] hit_count;
  logic [3:0] health;
  logic       boss_active, boss_enraged, boss_flash;
  logic       boss_exploding, boss_defeated, defeat_pulse;

  int compared   = 0;
  int mismatched = 0;

  // Model: mode 0 = waiting, 1 = fighting, 2 = exploding, 3 = defeated.
  int m_mode, m_hits, m_flash, m_death, m_prev;
  bit m_pulse;

  boss_health_fsm #(
    .MAX_HITS(MAXH), .ENRAGE_HITS(ENR), .FLASH_FRAMES(FLF), .DEATH_FRAMES(DTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .frame_tick     (frame_tick),
    .hit_count      (hit_count),
    .health         (health),
    .boss_active    (boss_active),
    .boss_enraged   (boss_enraged),
    .boss_flash     (boss_flash),
    .boss_exploding (boss_exploding),
    .boss_defeated  (boss_defeated),
    .defeat_pulse   (defeat_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_hits = 0; m_flash = 0; m_death = 0; m_prev = 0; m_pulse = 0;
  endtask

  task automatic model_step(input bit st, input bit tk, input int hc);
    int delta;
    delta   = ((hc - m_prev) % 16 + 16) % 16;
    m_prev  = hc;
    m_pulse = 0;
    if (st) begin
      m_mode = 1; m_hits = 0; m_flash = 0; m_death = 0;
    end else if (m_mode == 1) begin
      if (tk && m_flash > 0) m_flash--;
      if (delta != 0) begin
        m_flash = FLF;
        m_hits  = (m_hits + delta > MAXH) ? MAXH : m_hits + delta;
        if (m_hits >= MAXH) begin
          m_mode = 2; m_death = DTH; m_flash = 0;
        end
      end
    end else if (m_mode == 2) begin
      if (tk) begin
        m_death--;
        if (m_death == 0) begin
          m_mode = 3; m_pulse = 1;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".health"},    32'(health),         32'(MAXH - m_hits));
    chk({tag, ".active"},    32'(boss_active),    32'(m_mode == 1));
    chk({tag, ".enraged"},   32'(boss_enraged),   32'(m_mode == 1 && m_hits >= ENR));
    chk({tag, ".flash"},     32'(boss_flash),     32'(m_mode == 1 && m_flash > 0));
    chk({tag, ".exploding"}, 32'(boss_exploding), 32'(m_mode == 2));
    chk({tag, ".defeated"},  32'(boss_defeated),  32'(m_mode == 3));
    chk({tag, ".pulse"},     32'(defeat_pulse),   32'(m_pulse));
  endtask

  task automatic step(input string tag, input bit st, input bit tk, input int hc);
    start      = st;
    frame_tick = tk;
    hit_count  = 4'(hc);
    @(posedge clk);
    model_step(st, tk, hc & 15);
    #1;
    check_all(tag);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, ".health"}, 32'(health), 32'd10);
    chk({tag, ".flags"},
        32'({boss_active, boss_enraged, boss_flash, boss_exploding, boss_defeated, defeat_pulse}),
        32'd0);
  endtask

  initial begin
    int pulses;
    int hc;
    bit st, tk;

    // Reset state.
    reset = 1'b1; start = 1'b0; frame_tick = 1'b0; hit_count = 4'd0;
    model_reset();
    #12;
    check_reset_values("reset");
    check_all("reset_model");
    reset = 1'b0;

    // Arm, first hit, flash lasts 8 frame ticks.
    step("start", 1'b1, 1'b0, 0);
    step("hit1", 1'b0, 1'b0, 1);
    chk("hit1_health", 32'(health), 32'd9);
    chk("hit1_flash", 32'(boss_flash), 32'd1);
    for (int i = 0; i < FLF; i++) step("flash_decay", 1'b0, 1'b1, 1);
    chk("flash_expired", 32'(boss_flash), 32'd0);

    // Accumulate to the enrage threshold.
    for (int i = 2; i <= 5; i++) step("accumulate", 1'b0, 1'b0, i);
    chk("enraged", 32'(boss_enraged), 32'd1);
    chk("enraged_active", 32'(boss_active), 32'd1);
    chk("enraged_health", 32'(health), 32'd5);

    // Re-arm (start wins over a count change), then one big jump 3 -> 12.
    step("rearm", 1'b1, 1'b0, 0);
    for (int i = 1; i <= 3; i++) step("pre_jump", 1'b0, 1'b0, i);
    step("jump", 1'b0, 1'b0, 12);
    chk("jump_exploding", 32'(boss_exploding), 32'd1);
    chk("jump_health", 32'(health), 32'd0);
    chk("jump_not_enraged", 32'(boss_enraged), 32'd0);

    // Explosion: a tick every other cycle, 60 ticks in total.
    pulses = 0;
    for (int i = 0; i < 2 * DTH; i++) begin
      step("dying", 1'b0, 1'(i % 2), 12);
      if (defeat_pulse) pulses++;
    end
    chk("defeated_after_60", 32'(boss_defeated), 32'd1);
    step("defeated_hold", 1'b0, 1'b1, 13);
    if (defeat_pulse) pulses++;
    step("defeated_hold", 1'b0, 1'b0, 2);
    if (defeat_pulse) pulses++;
    chk("defeat_pulse_count", 32'(pulses), 32'd1);
    chk("defeated_health", 32'(health), 32'd0);

    // Wrap 15 -> 0 counts as one hit.
    step("arm_wrap", 1'b1, 1'b0, 14);
    step("to15", 1'b0, 1'b0, 15);
    step("wrap", 1'b0, 1'b0, 0);
    chk("wrap_health", 32'(health), 32'd8);

    // Hit on the same cycle as a frame tick reloads the flash timer.
    for (int i = 0; i < 3; i++) step("flash_part", 1'b0, 1'b1, 0);
    step("hit_and_tick", 1'b0, 1'b1, 1);
    for (int i = 0; i < FLF; i++) step("flash_reload", 1'b0, 1'b1, 1);
    chk("flash_reload_end", 32'(boss_flash), 32'd0);

    // Start coincident with a hit: the hit is discarded.
    step("start_hit", 1'b1, 1'b0, 4);
    chk("start_hit_health", 32'(health), 32'd10);

    // Asynchronous reset in the middle of the explosion.
    step("kill", 1'b0, 1'b0, 14);
    for (int i = 0; i < 5; i++) step("dying2", 1'b0, 1'b1, 14);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_reset_values("async_reset");
    @(negedge clk);
    reset = 1'b0;

    // Random play against the model.
    hc = 14;
    for (int i = 0; i < 2000; i++) begin
      st = ($urandom_range(0, 59) == 0);
      tk = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 19))
        0:             hc = (hc + int'($urandom_range(3, 15))) % 16;
        1, 2, 3, 4, 5: hc = (hc + int'($urandom_range(1, 2))) % 16;
        default:       hc = hc;
      endcase
      step("random", st, tk, hc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/boss_health_fsm.md
# boss_health_fsm

Downstream consumer of the boss hit counter. Converts the 4-bit cumulative hit count into boss health, a hit-flash effect, an enrage phase and a timed death/explosion sequence. Its outputs drive the boss sprite renderer, the boss movement/firing logic and the game-over/win logic. All outputs are registered; animation timing advances on the per-frame tick from the VGA timing block.

## Interface
Parameters:
- MAX_HITS, 10: hits needed to kill the boss (1..15).
- ENRAGE_HITS, 5: hits at which the boss enters the enraged phase (1..MAX_HITS-1).
- FLASH_FRAMES, 8: frames `boss_flash` stays high after each hit.
- DEATH_FRAMES, 60: frames spent in the explosion sequence.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- start, in, 1: one-cycle pulse that (re)arms the boss.
- frame_tick, in, 1: one-cycle pulse per video frame.
- hit_count, in, 4: cumulative hit count from the hit counter.
- health, out, 4: remaining hits, MAX_HITS minus hits taken, floored at 0.
- boss_active, out, 1: boss is drawn, collidable and firing (ALIVE or ENRAGED).
- boss_enraged, out, 1: high in ENRAGED.
- boss_flash, out, 1: high during hit flash.
- boss_exploding, out, 1: high in DYING.
- boss_defeated, out, 1: high in DEFEATED (level).
- defeat_pulse, out, 1: one-cycle pulse on entry to DEFEATED.

## Operation
- Reset: state IDLE, hits_taken=0, prev_count=0, health=MAX_HITS, all flags 0.
- Hit detection:
  - delta = hit_count − prev_count, modulo 16, 4-bit.
  - prev_count ← hit_count every cycle.
  - The hit_count wrap from 15 to 0 counts as delta=1.
- In ALIVE and ENRAGED:
  - A nonzero delta adds to hits_taken, saturating at MAX_HITS.
  - It also (re)loads the flash timer with FLASH_FRAMES.
- In IDLE, DYING and DEFEATED: delta is ignored. prev_count still tracks hit_count.
- States:
  - IDLE: waits for `start`. Then hits_taken=0, prev_count←hit_count (no delta credited), next state ALIVE.
  - ALIVE: updated hits_taken ≥ MAX_HITS → DYING. Otherwise ≥ ENRAGE_HITS → ENRAGED.
  - ENRAGED: updated hits_taken ≥ MAX_HITS → DYING.
  - DYING: death timer is loaded with DEATH_FRAMES on entry. Each frame_tick decrements it; reaching 0 → DEFEATED. The flash timer is cleared on entry.
  - DEFEATED: holds. `start` re-arms exactly as from IDLE.
- A single large delta may jump ALIVE → DYING directly, skipping ENRAGED.
- Flash timer:
  - Decrements on frame_tick while nonzero.
  - boss_flash = (timer ≠ 0) and boss_active.
- `start` in ALIVE, ENRAGED or DYING restarts the boss: ALIVE, hits_taken=0, timers cleared.
- health = MAX_HITS − hits_taken, computed in 5-bit width and floored at 0.

## Timing
- Latency of one cycle:
  - hit_count change sampled at edge N → health, state, flags and flash valid after edge N.
  - This is one cycle after hit_count itself changed (the counter is registered).
- The flash load and the state transition happen on the same edge.
- Simultaneous events:
  - frame_tick and a hit on the same cycle: the reload wins (timer = FLASH_FRAMES).
  - `start` and a nonzero delta on the same cycle: `start` wins; the delta is discarded.
- defeat_pulse is high exactly one cycle, on the edge where the state becomes DEFEATED.
- Boss visible duration:
  - Explosion lasts DEATH_FRAMES frame_ticks after DYING entry.
  - A frame_tick on the entry cycle is not counted.
- Asynchronous reset mid-sequence (any state) returns immediately to reset values. No pulse is emitted.

## Structure
- Shared package `boss_pkg`:
  - boss_state_t enum {IDLE, ALIVE, ENRAGED, DYING, DEFEATED}.
  - HIT_W=4.
  - Default constants MAX_HITS, ENRAGE_HITS, FLASH_FRAMES, DEATH_FRAMES.
- One sub-module, `boss_frame_timer`:
  - Parameterised down-counter with load, clear, frame_tick decrement and `zero` output.
  - Instantiated twice: flash timer and death timer.
- The state machine and hits_taken accumulator live in the top module.

## Test plan
- Reset, then start, then hit_count 0→1 → health 10→9 one cycle later; boss_flash high for 8 frame_ticks, then low.
- Hits accumulate to 5 → boss_enraged=1, boss_active=1, health=5.
- hit_count jumps 3→12 in one step while ALIVE → hits_taken saturates at 10, state DYING, health=0, boss_enraged never asserted.
- DYING with 60 frame_ticks → boss_exploding high for 60 ticks; defeat_pulse exactly 1 cycle; boss_defeated stays 1; further hit_count changes leave health=0.
- hit_count wrap 15→0 while ALIVE → counted as one hit.
- Edge-case bundle:
  - Hit and frame_tick on the same cycle → flash reloads to 8.
  - `start` coincident with a hit → health=10.
  - Reset asserted mid-DYING → all outputs 0 and health=10 immediately.
